multdiv_sequencer: RTL and testbench

- Execute-stage controller that sequences the shared multi-cycle multiplier/divider for R-type mul and div.
- Detects mul/div in the X stage, stalls the pipeline, and issues a one-cycle start pulse to the multdiv unit.
- Waits for the ready signal or a timeout, then presents writeback data, register and write enable to the X/M latch for one cycle.
- Arithmetic exceptions are redirected to r30 with an rstatus code.

---
 rtl/multdiv_sequencer.sv | 149 ++++++++++++++
 tb/tb_multdiv_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_sequencer.sv
// Execute-stage sequencer for the shared multi-cycle multiplier/divider.
// Detects R-type mul/div in X, stalls the pipe, issues a start pulse and returns writeback data.
module multdiv_sequencer #(
  parameter int unsigned TIMEOUT    = 40,
  parameter int unsigned MUL_STATUS = 4,
  parameter int unsigned DIV_STATUS = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] x_instruction,
  input  logic [31:0] x_operandA,
  input  logic [31:0] x_operandB,
  input  logic        md_resultRDY,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        stall,
  output logic        busy,
  output logic        md_done,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_wren,
  output logic [1:0]  state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] counter_q;
  logic [31:0]      opa_q, opb_q, result_q;
  logic [4:0]       rd_q;
  logic             op_div_q, exc_q;

  logic [4:0] opcode, aluop, rd;
  logic       is_mul, is_div, is_md;
  logic       unused_bits;

  assign opcode      = x_instruction[31:27];
  assign rd          = x_instruction[26:22];
  assign aluop       = x_instruction[6:2];
  assign is_mul      = (opcode == 5'b00000) && (aluop == 5'b00110);
  assign is_div      = (opcode == 5'b00000) && (aluop == 5'b00111);
  assign is_md       = is_mul || is_div;
  assign unused_bits = ^{x_instruction[21:7], x_instruction[1:0]};

  // Handshake with the multdiv unit: ctrl_MULT/ctrl_DIV is a single-cycle start
  // (no back-pressure); md_resultRDY is the valid for md_result/md_exception and
  // is only honoured in WAIT, so a stale RDY seen during ISSUE is ignored.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    md_done   = 1'b0;
    wb_data   = 32'd0;
    wb_reg    = 5'd0;
    wb_wren   = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (is_md) begin
          stall   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        stall     = 1'b1;
        ctrl_MULT = !op_div_q;
        ctrl_DIV  = op_div_q;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (md_resultRDY || (counter_q == CNT_LAST)) state_d = S_DONE;
      end
      S_DONE: begin
        md_done = 1'b1;
        state_d = S_IDLE;
        if (exc_q) begin
          wb_reg  = 5'd30;
          wb_data = op_div_q ? 32'(DIV_STATUS) : 32'(MUL_STATUS);
          wb_wren = 1'b1;
        end else begin
          wb_reg  = rd_q;
          wb_data = result_q;
          wb_wren = (rd_q != 5'd0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      counter_q <= '0;
      opa_q     <= 32'd0;
      opb_q     <= 32'd0;
      result_q  <= 32'd0;
      rd_q      <= 5'd0;
      op_div_q  <= 1'b0;
      exc_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_md) begin
            opa_q    <= x_operandA;
            opb_q    <= x_operandB;
            rd_q     <= rd;
            op_div_q <= is_div;
          end
        end
        S_ISSUE: counter_q <= '0;
        S_WAIT: begin
          counter_q <= counter_q + 1'b1;
          // RDY on the final WAIT cycle still wins over the timeout.
          if (md_resultRDY) begin
            result_q <= md_result;
            exc_q    <= md_exception;
          end else if (counter_q == CNT_LAST) begin
            exc_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign md_opA    = opa_q;
  assign md_opB    = opb_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomized bench for multdiv_sequencer: a transaction-level model predicts the
// cycle timeline and writeback of each mul/div; a scoreboard queue holds expected results.
module tb_multdiv_sequencer;

  localparam int TIMEOUT = 40;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [31:0] x_instruction, x_operandA, x_operandB, md_result;
  logic        md_resultRDY, md_exception;
  logic        ctrl_MULT, ctrl_DIV, stall, busy, md_done, wb_wren;
  logic [31:0] md_opA, md_opB, wb_data;
  logic [4:0]  wb_reg;
  logic [1:0]  state_dbg;

  multdiv_sequencer #(.TIMEOUT(TIMEOUT), .MUL_STATUS(4), .DIV_STATUS(5)) dut (
    .clock(clock), .reset(reset),
    .x_instruction(x_instruction), .x_operandA(x_operandA), .x_operandB(x_operandB),
    .md_resultRDY(md_resultRDY), .md_exception(md_exception), .md_result(md_result),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .md_opA(md_opA), .md_opB(md_opB),
    .stall(stall), .busy(busy), .md_done(md_done),
    .wb_data(wb_data), .wb_reg(wb_reg), .wb_wren(wb_wren), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [37:0] exp_q[$];  // {wren, reg, data}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model
  function automatic logic [37:0] model_wb(input bit div, input logic [4:0] rd,
                                           input logic [31:0] res, input bit exc, input bit timed_out);
    if (exc || timed_out) return {1'b1, 5'd30, (div ? 32'd5 : 32'd4)};
    return {(rd != 5'd0), rd, res};
  endfunction

  function automatic logic [31:0] mk_op(input bit div, input logic [4:0] rd);
    logic [4:0] rs, rt;
    rs = 5'($urandom);
    rt = 5'($urandom);
    return {5'b00000, rd, rs, rt, 5'd0, (div ? 5'b00111 : 5'b00110), 2'b00};
  endfunction

  function automatic logic [31:0] nonop();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: r = {5'b00000, r[26:7], 5'b00101, r[1:0]};
      1: r = {5'b00001, r[26:7], 5'b00110, r[1:0]};
      2: r = {5'b00000, r[26:7], 5'b01110, r[1:0]};
      default: if (r[31:27] == 5'd0 && r[6:3] == 4'b0011) r[31] = 1'b1;
    endcase
    return r;
  endfunction

  // driver tasks: each starts just after a rising edge, checks at the falling edge
  task automatic to_next();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mult"}, ctrl_MULT, 0);
    check({tag, "_div"}, ctrl_DIV, 0);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, md_done, 0);
    check({tag, "_wbdata"}, wb_data, 0);
    check({tag, "_wbreg"}, wb_reg, 0);
    check({tag, "_wbwren"}, wb_wren, 0);
    check({tag, "_opa"}, md_opA, 0);
    check({tag, "_opb"}, md_opB, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      x_instruction = nonop();
      x_operandA    = $urandom;
      x_operandB    = $urandom;
      md_resultRDY  = 1'($urandom_range(0, 1));
      md_result     = $urandom;
      md_exception  = 1'($urandom_range(0, 1));
      @(negedge clock);
      check("idle_stall", stall, 0);
      check("idle_busy", busy, 0);
      check("idle_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
      check("idle_done", md_done, 0);
      check("idle_wren", wb_wren, 0);
      to_next();
    end
  endtask

  // rdy_at: WAIT cycle (1-based) carrying RDY; 0 or > TIMEOUT means never.
  // abort_at: WAIT cycle in which reset is asserted (0 = no abort).
  task automatic run_op(input bit div, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int rdy_at, input logic [31:0] res,
                        input bit exc, input int abort_at);
    logic [37:0] exp;
    bit timed_out;
    int last;
    timed_out = (rdy_at == 0) || (rdy_at > TIMEOUT);
    last      = timed_out ? TIMEOUT : rdy_at;
    exp_q.push_back(model_wb(div, rd, res, exc, timed_out));

    x_instruction = mk_op(div, rd);
    x_operandA    = a;
    x_operandB    = b;
    md_resultRDY  = 1'b0;
    md_result     = $urandom;
    md_exception  = 1'($urandom_range(0, 1));
    @(negedge clock);
    check("detect_stall", stall, 1);
    check("detect_busy", busy, 0);
    check("detect_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
    to_next();

    md_resultRDY = 1'($urandom_range(0, 1));
    md_result    = $urandom;
    md_exception = 1'($urandom_range(0, 1));
    x_operandA   = $urandom;
    x_operandB   = $urandom;
    @(negedge clock);
    check("issue_mult", ctrl_MULT, !div);
    check("issue_div", ctrl_DIV, div);
    check("issue_stall", stall, 1);
    check("issue_busy", busy, 1);
    check("issue_opa", md_opA, a);
    check("issue_opb", md_opB, b);
    to_next();

    for (int j = 1; j <= last; j++) begin
      bit hit;
      hit          = (j == rdy_at);
      reset        = (j == abort_at);
      md_resultRDY = hit;
      md_result    = hit ? res : $urandom;
      md_exception = hit ? exc : 1'($urandom_range(0, 1));
      x_operandA   = $urandom;
      @(negedge clock);
      check("wait_stall", stall, 1);
      check("wait_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
      check("wait_done", md_done, 0);
      check("wait_opa", md_opA, a);
      check("wait_opb", md_opB, b);
      to_next();
      if (j == abort_at) begin
        reset         = 1'b0;
        x_instruction = nonop();
        md_resultRDY  = 1'b0;
        @(negedge clock);
        check_all_zero("abort");
        void'(exp_q.pop_back());
        to_next();
        return;
      end
    end

    md_resultRDY = 1'b0;
    md_result    = $urandom;
    @(negedge clock);
    exp = exp_q.pop_front();
    check("done_pulse", md_done, 1);
    check("done_stall", stall, 0);
    check("done_busy", busy, 1);
    check("done_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
    check("wb_wren", wb_wren, exp[37]);
    check("wb_reg", wb_reg, exp[36:32]);
    check("wb_data", wb_data, exp[31:0]);
    to_next();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    x_instruction = 32'd0;
    x_operandA    = 32'd0;
    x_operandB    = 32'd0;
    md_resultRDY  = 1'b0;
    md_exception  = 1'b0;
    md_result     = 32'd0;
    to_next();
    @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    to_next();

    idle_cycles(3);
    run_op(0, 5'd3, 32'd6, 32'd7, 3, 32'd42, 0, 0);            // mul r3 = 42
    run_op(1, 5'd4, 32'd9, 32'd0, 2, 32'hdead, 1, 0);          // div by zero
    run_op(0, 5'd0, 32'd5, 32'd5, 1, 32'd25, 0, 0);            // rd = 0
    run_op(0, 5'd7, 32'd1, 32'd2, 0, 32'd0, 0, 0);             // mul timeout
    run_op(1, 5'd8, 32'd3, 32'd4, 0, 32'd0, 0, 0);             // div timeout
    run_op(0, 5'd9, 32'd8, 32'd8, TIMEOUT, 32'd64, 0, 0);      // RDY on last cycle
    run_op(0, 5'd10, 32'd2, 32'd3, 1, 32'd6, 0, 0);            // back-to-back pair
    run_op(0, 5'd11, 32'd4, 32'd5, 1, 32'd20, 0, 0);
    run_op(0, 5'd5, 32'd11, 32'd12, 10, 32'd99, 0, 4);         // reset in WAIT
    run_op(0, 5'd5, 32'd11, 32'd12, 3, 32'd132, 0, 0);
    idle_cycles(2);

    for (int k = 0; k < 40; k++) begin
      int rdy_at;
      if ($urandom_range(0, 5) == 0) rdy_at = $urandom_range(TIMEOUT - 1, TIMEOUT + 2);
      else if ($urandom_range(0, 9) == 0) rdy_at = 0;
      else rdy_at = $urandom_range(1, 8);
      run_op(1'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom, rdy_at,
             $urandom, ($urandom_range(0, 3) == 0), 0);
      idle_cycles($urandom_range(0, 2));
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
